cpu_storebuffer_drain: RTL and testbench
========================================

// Module: cpu_storebuffer_drain
// PURPOSE
// - Drain scheduler for the store buffer. Pops the head entry and writes it into the D-cache write port.
// - Arbitrates the single cache port between pipeline loads and store drains, with loads preferred.
// - On a drain miss, sequences a line fill through the memory port, then replays the write.
// - Implements flush/fence: empties the buffer on request and signals completion.
// PARAMETERS
// - TAG_WIDTH     `PHYSICAL_ADDR_WIDTH  store address width
// - DATA_WIDTH    `WORD_WIDTH           store data width
// - LINE_OFFSET   4                     log2 line bytes; fill address low bits cleared
// - STARVE_LIMIT  8                     consecutive load-blocked cycles before drain takes priority
// PORTS
// - clock          in   1            single clock, posedge
// - reset          in   1            asynchronous, active-high
// - sb_empty       in   1            store buffer empty
// - sb_full        in   1            store buffer full
// - sb_tag_pop     in   TAG_WIDTH    head entry address (word aligned)
// - sb_data_pop    in   DATA_WIDTH   head entry data
// - sb_bytes_pop   in   4            head entry byte enables
// - sb_pop         out  1            pop head this cycle
// - load_req       in   1            pipeline load wants the cache port this cycle
// - load_grant     out  1            load owns the cache port this cycle
// - flush_req      in   1            one-cycle fence/flush request
// - flush_done     out  1            one-cycle pulse: buffer drained after flush
// - cache_wr_en    out  1            cache write lookup/commit
// - cache_wr_addr  out  TAG_WIDTH    = sb_tag_pop
// - cache_wr_data  out  DATA_WIDTH   = sb_data_pop
// - cache_wr_bytes out  4            = sb_bytes_pop
// - cache_hit      in   1            combinational hit for cache_wr_addr, same cycle
// - mem_req        out  1            line fill request, held until mem_ack
// - mem_addr       out  TAG_WIDTH    {sb_tag_pop[TAG_WIDTH-1:LINE_OFFSET], LINE_OFFSET'b0}
// - mem_ack        in   1            fill complete, line written into cache
// BEHAVIOUR
// - Reset values: sb_pop, load_grant, flush_done, cache_wr_en and mem_req are 0. FSM is IDLE, flush_pend=0, starve_cnt=0.
// - urgent = sb_full | flush_pend | (starve_cnt==STARVE_LIMIT) | (state==REPLAY).
// - IDLE / REPLAY:
//   - drain_go = ~sb_empty & (~load_req | urgent).
//   - load_grant = load_req & ~drain_go.
//   - cache_wr_en = drain_go.
//   - drain_go & cache_hit: sb_pop=1 in the same cycle (zero-latency commit); next state IDLE.
//   - drain_go & ~cache_hit: sb_pop=0; next state FILL.
// - FILL:
//   - mem_req=1, cache_wr_en=0, load_grant=0 (cache being refilled).
//   - mem_ack: next state REPLAY.
//   - REPLAY forces the drain; a miss in REPLAY re-enters FILL.
// - Head entry is never popped without a hit commit; data is not buffered internally.
// - starve_cnt:
//   - Increments, saturating at STARVE_LIMIT, in cycles where ~sb_empty & load_req & ~drain_go.
//   - Clears on sb_pop or sb_empty.
//   - Width is $clog2(STARVE_LIMIT+1).
// - Flush:
//   - flush_req sets flush_pend.
//   - flush_done pulses for 1 cycle, one cycle after (flush_pend & sb_empty & state==IDLE); flush_pend clears then.
//   - flush_req while already pending is absorbed (single done).
//   - flush_req with an empty buffer gives flush_done on the next cycle.
// - Boundaries:
//   - A push in the same cycle as sb_pop is legal; the buffer handles it.
//   - sb_full with load_req: the drain wins and load_grant=0.
//   - mem_ack outside FILL is ignored.
//   - Reset mid-FILL drops mem_req immediately; the memory side must tolerate an abandoned request.
//   - sb_empty in REPLAY (only possible after an external reset) returns to IDLE.
// STRUCTURE
// - Shared package CPU_cache_types.svh adds:
//   - typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_FILL, DRAIN_REPLAY} CPU_drain_state_e;
//   - `define STARVE_LIMIT.
// - One natural sub-module: cpu_sat_counter (saturating up-counter with clear).
// - Remaining logic: FSM plus combinational arbitration, single always_ff with async reset.
// TESTING
// - Idle load priority: sb holds 1 entry, load_req=1 for 3 cycles, urgent=0 -> load_grant=1, sb_pop=0, starve_cnt=3.
// - Starvation: load_req held high, STARVE_LIMIT=8 -> on the 9th cycle drain_go=1, load_grant=0, and sb_pop with cache_hit=1.
// - Miss/fill: head tag 0x1234, cache_hit=0 -> mem_req=1 with mem_addr 0x1230; mem_ack after 5 cycles -> REPLAY commits, sb_pop=1 the next cycle.
// - Full override: sb_full=1, load_req=1, cache_hit=1 -> load_grant=0, sb_pop=1 the same cycle.
// - Flush: 3 entries, all hits, flush_req pulse -> 3 consecutive pops despite load_req, then one flush_done pulse.
// - Async reset mid-FILL: assert reset between clock edges -> mem_req=0 immediately, state IDLE, flush_done=0.

Source files
------------

// File: rtl/cpu_storebuffer_drain_pkg.sv
// Shared types and default widths for the store-buffer drain scheduler.
package cpu_storebuffer_drain_pkg;

  localparam int PHYS_ADDR_WIDTH      = 32;
  localparam int WORD_WIDTH           = 32;
  localparam int LINE_OFFSET_DEFAULT  = 4;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  // Drain sequencer states: normal arbitration, line fill in flight, forced rewrite after fill.
  typedef enum logic [1:0] {
    DRAIN_IDLE   = 2'd0,
    DRAIN_FILL   = 2'd1,
    DRAIN_REPLAY = 2'd2
  } drain_state_e;

endpackage

// File: rtl/cpu_storebuffer_drain_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cpu_sat_counter #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, hold at the limit, or step by one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIMIT_V))
      cnt_d = cnt_q + W'(1);
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/cpu_storebuffer_drain.sv
// Store-buffer drain scheduler: shares the D-cache write port with loads,
// sequences line fills on a drain miss, and implements flush/fence.
//
// Handshakes: the head entry is consumed only when sb_pop is high, which
// happens only in a cycle where cache_wr_en and cache_hit are both high
// (zero-latency commit). mem_req is a level held until mem_ack; mem_ack is
// honoured only in DRAIN_FILL. load_grant is a same-cycle answer to load_req.
module cpu_storebuffer_drain
  import cpu_storebuffer_drain_pkg::*;
#(
  parameter int TAG_WIDTH    = PHYS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = WORD_WIDTH,
  parameter int LINE_OFFSET  = LINE_OFFSET_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sb_empty,
  input  logic                  sb_full,
  input  logic [TAG_WIDTH-1:0]  sb_tag_pop,
  input  logic [DATA_WIDTH-1:0] sb_data_pop,
  input  logic [3:0]            sb_bytes_pop,
  output logic                  sb_pop,
  input  logic                  load_req,
  output logic                  load_grant,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  cache_wr_en,
  output logic [TAG_WIDTH-1:0]  cache_wr_addr,
  output logic [DATA_WIDTH-1:0] cache_wr_data,
  output logic [3:0]            cache_wr_bytes,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic [TAG_WIDTH-1:0]  mem_addr,
  input  logic                  mem_ack,
  output drain_state_e          dbg_state,
  output logic [CNT_W-1:0]      dbg_starve_cnt,
  output logic                  dbg_flush_pend
);

  drain_state_e     state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic             flush_done_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_sat;
  logic             in_fill, urgent, drain_go;
  logic             flush_active, done_cond;
  logic             starve_inc, starve_clr;

  // Counts consecutive cycles a waiting store loses the port to loads.
  cpu_sat_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .cnt_o (starve_cnt),
    .sat_o (starve_sat)
  );

  // Port arbitration, commit decision and next-state selection.
  always_comb begin
    in_fill      = (state_q == DRAIN_FILL);
    urgent       = sb_full | flush_pend_q | starve_sat | (state_q == DRAIN_REPLAY);
    drain_go     = ~in_fill & ~sb_empty & (~load_req | urgent);
    load_grant   = ~in_fill & load_req & ~drain_go;
    cache_wr_en  = drain_go;
    sb_pop       = drain_go & cache_hit;
    mem_req      = in_fill;
    starve_inc   = ~sb_empty & load_req & ~drain_go;
    starve_clr   = sb_pop | sb_empty;
    flush_active = flush_pend_q | flush_req;
    done_cond    = flush_active & sb_empty & (state_q == DRAIN_IDLE);
    flush_pend_d = flush_active & ~done_cond;
    state_d      = state_q;
    case (state_q)
      DRAIN_FILL: if (mem_ack) state_d = DRAIN_REPLAY;
      // IDLE and REPLAY arbitrate alike; a replay with an empty buffer falls back to IDLE.
      default:    state_d = (drain_go & ~cache_hit) ? DRAIN_FILL : DRAIN_IDLE;
    endcase
  end

  // Sequencer state, pending-flush flag and registered flush completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= DRAIN_IDLE;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= done_cond;
    end
  end

  assign flush_done     = flush_done_q;
  assign cache_wr_addr  = sb_tag_pop;
  assign cache_wr_data  = sb_data_pop;
  assign cache_wr_bytes = sb_bytes_pop;
  assign mem_addr       = {sb_tag_pop[TAG_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt;
  assign dbg_flush_pend = flush_pend_q;

endmodule

// File: tb/tb_cpu_storebuffer_drain.sv
// Bench for cpu_storebuffer_drain: models the store buffer as a queue and the
// scheduler as a set of flags, then drives directed and random traffic.
module tb_cpu_storebuffer_drain;
  import cpu_storebuffer_drain_pkg::*;

  localparam int LIMIT = 8;
  localparam int DEPTH = 4;

  logic        clock, reset;
  logic        sb_empty, sb_full;
  logic [31:0] sb_tag_pop, sb_data_pop;
  logic [3:0]  sb_bytes_pop;
  logic        sb_pop, load_req, load_grant, flush_req, flush_done;
  logic        cache_wr_en, cache_hit, mem_req, mem_ack;
  logic [31:0] cache_wr_addr, cache_wr_data, mem_addr;
  logic [3:0]  cache_wr_bytes;
  drain_state_e dbg_state;
  logic [3:0]  dbg_starve_cnt;
  logic        dbg_flush_pend;

  cpu_storebuffer_drain dut (
    .clock          (clock),
    .reset          (reset),
    .sb_empty       (sb_empty),
    .sb_full        (sb_full),
    .sb_tag_pop     (sb_tag_pop),
    .sb_data_pop    (sb_data_pop),
    .sb_bytes_pop   (sb_bytes_pop),
    .sb_pop         (sb_pop),
    .load_req       (load_req),
    .load_grant     (load_grant),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .cache_wr_en    (cache_wr_en),
    .cache_wr_addr  (cache_wr_addr),
    .cache_wr_data  (cache_wr_data),
    .cache_wr_bytes (cache_wr_bytes),
    .cache_hit      (cache_hit),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt),
    .dbg_flush_pend (dbg_flush_pend)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: store-buffer contents as {tag, data, bytes}, head at index 0.
  logic [67:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Behavioural view of the scheduler.
  bit m_filling, m_replay, m_pend, m_done;
  int m_starve;

  // Observations kept from the most recent step for directed checks.
  logic        last_pop, last_grant, last_done;
  logic [31:0] last_maddr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_filling = 0; m_replay = 0; m_pend = 0; m_done = 0; m_starve = 0;
  endtask

  // One clock cycle: drive at negedge, check combinational and registered outputs, update model at posedge.
  task automatic step(input bit ld, input bit fl, input bit hit, input bit ack,
                      input bit push, input logic [31:0] ptag);
    bit empty, full, urgent, drain, e_pop, e_grant, e_wr, e_mreq, active, done_now;
    logic [67:0]  head;
    drain_state_e e_state;
    @(negedge clock);
    empty = (exp_q.size() == 0);
    full  = (exp_q.size() == DEPTH);
    head  = empty ? 68'd0 : exp_q[0];
    sb_empty = empty; sb_full = full;
    sb_tag_pop = head[67:36]; sb_data_pop = head[35:4]; sb_bytes_pop = head[3:0];
    load_req = ld; flush_req = fl; cache_hit = hit; mem_ack = ack;
    #1;
    if (m_filling) begin
      drain = 0; e_wr = 0; e_grant = 0; e_pop = 0; e_mreq = 1;
    end else begin
      urgent  = full || m_pend || (m_starve == LIMIT) || m_replay;
      drain   = !empty && (!ld || urgent);
      e_wr    = drain;
      e_grant = ld && !drain;
      e_pop   = drain && hit;
      e_mreq  = 0;
    end
    e_state = m_filling ? DRAIN_FILL : (m_replay ? DRAIN_REPLAY : DRAIN_IDLE);
    check("sb_pop", 64'(sb_pop), 64'(e_pop));
    check("load_grant", 64'(load_grant), 64'(e_grant));
    check("cache_wr_en", 64'(cache_wr_en), 64'(e_wr));
    check("mem_req", 64'(mem_req), 64'(e_mreq));
    check("flush_done", 64'(flush_done), 64'(m_done));
    check("starve_cnt", 64'(dbg_starve_cnt), 64'(m_starve));
    check("state", 64'(dbg_state), 64'(e_state));
    if (e_wr) begin
      check("wr_addr", 64'(cache_wr_addr), 64'(head[67:36]));
      check("wr_data", 64'(cache_wr_data), 64'(head[35:4]));
      check("wr_bytes", 64'(cache_wr_bytes), 64'(head[3:0]));
    end
    if (e_mreq) check("mem_addr", 64'(mem_addr), 64'(head[67:36] & ~32'hF));
    last_pop = sb_pop; last_grant = load_grant; last_done = flush_done; last_maddr = mem_addr;
    @(posedge clock);
    // Starvation bookkeeping.
    if (e_pop || empty) m_starve = 0;
    else if (ld && !drain && m_starve < LIMIT) m_starve++;
    // Flush completion is seen one cycle after the drained, idle condition.
    active   = m_pend || fl;
    done_now = active && empty && !m_filling && !m_replay;
    m_done   = done_now;
    m_pend   = active && !done_now;
    // Miss handling.
    if (m_filling) begin
      if (ack) begin m_filling = 0; m_replay = 1; end
    end else begin
      m_filling = drain && !hit;
      m_replay  = 0;
    end
    // External buffer: pop the committed head, then accept a new store if there was room.
    if (e_pop) void'(exp_q.pop_front());
    if (push && !full) exp_q.push_back({ptag, 32'($urandom), 4'($urandom)});
  endtask

  initial begin
    int pops, dones;
    // Reset and idle outputs.
    reset = 1'b1; sb_empty = 1'b1; sb_full = 1'b0; sb_tag_pop = '0; sb_data_pop = '0;
    sb_bytes_pop = '0; load_req = 1'b0; flush_req = 1'b0; cache_hit = 1'b0; mem_ack = 1'b0;
    model_reset();
    #3;
    check("rst_sb_pop", 64'(sb_pop), 64'd0);
    check("rst_load_grant", 64'(load_grant), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_cache_wr_en", 64'(cache_wr_en), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(DRAIN_IDLE));
    check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Load priority, then starvation forcing the drain on the 9th blocked cycle.
    step(1, 0, 1, 0, 1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, '0);
    #1 check("starve_3", 64'(dbg_starve_cnt), 64'd3);
    check("load_prio_grant", 64'(last_grant), 64'd1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, '0);
    step(1, 0, 1, 0, 0, '0);
    check("starve_pop", 64'(last_pop), 64'd1);
    check("starve_grant", 64'(last_grant), 64'd0);

    // Miss, line fill with a 5-cycle acknowledge, then replay commit despite a load.
    step(0, 0, 1, 0, 1, 32'h0000_1234);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, '0);
    check("fill_addr", 64'(last_maddr), 64'h1230);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, '0);
    step(0, 0, 1, 1, 0, '0);
    step(1, 0, 1, 0, 0, '0);
    check("replay_pop", 64'(last_pop), 64'd1);

    // Full buffer overrides a load.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 1, 32'h100 + 32'(i * 4));
    step(1, 0, 1, 0, 0, '0);
    check("full_grant", 64'(last_grant), 64'd0);
    check("full_pop", 64'(last_pop), 64'd1);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(0, 0, 1, 0, 0, '0);

    // Flush with three entries: three pops under load pressure, one done pulse.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 32'h200 + 32'(i * 4));
    pops = 0; dones = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, i == 0, 1, 0, 0, '0);
      pops += int'(last_pop); dones += int'(last_done);
    end
    check("flush_pops", 64'(pops), 64'd3);
    check("flush_dones", 64'(dones), 64'd1);

    // Flush with an empty buffer completes on the next cycle.
    step(0, 1, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    check("empty_flush_done", 64'(last_done), 64'd1);

    // Asynchronous reset in the middle of a fill.
    step(0, 0, 1, 0, 1, 32'h0000_3000);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, '0);
    #1 check("fill_before_rst", 64'(mem_req), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_fill_mem_req", 64'(mem_req), 64'd0);
    check("rst_fill_state", 64'(dbg_state), 64'(DRAIN_IDLE));
    check("rst_fill_done", 64'(flush_done), 64'd0);
    model_reset();
    @(posedge clock); #1 reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40, $urandom & ~32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
